// File: rtl/alu_result_stage.sv
// Result stage behind the ALU. It captures the Z pair on start and drains it to the
// register-file write port: LO only for normal ops, LO then HI for mul/div.
module alu_result_stage #(
  parameter int          WIDTH  = 32,
  parameter logic [4:0]  OP_MUL = 5'b01111,
  parameter logic [4:0]  OP_DIV = 5'b10000,
  parameter int          CNT_W  = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] Zlowin,
  input  logic [WIDTH-1:0] Zhighin,
  input  logic [4:0]       op,
  input  logic             start,
  input  logic             out_ready,
  input  logic             ovr_ack,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_hi,
  output logic             busy,
  output logic [WIDTH-1:0] Zlow_q,
  output logic [WIDTH-1:0] Zhigh_q,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             overrun,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t state;
  logic   wide;
  logic   op_wide;
  logic   ovr_set;

  assign op_wide = (op == OP_MUL) || (op == OP_DIV);
  // The final handshake cycle is still a busy cycle, so a start landing there is an overrun.
  assign ovr_set = start && (state != IDLE);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      wide      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hi    <= 1'b0;
      busy      <= 1'b0;
      Zlow_q    <= '0;
      Zhigh_q   <= '0;
      zero_flag <= 1'b0;
      neg_flag  <= 1'b0;
      overrun   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_ack) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            Zlow_q    <= Zlowin;
            Zhigh_q   <= Zhighin;
            wide      <= op_wide;
            zero_flag <= op_wide ? ({Zhighin, Zlowin} == '0) : (Zlowin == '0);
            neg_flag  <= op_wide ? Zhighin[WIDTH-1] : Zlowin[WIDTH-1];
            out_data  <= Zlowin;
            out_hi    <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (out_ready) begin
            if (wide) begin
              out_data <= Zhigh_q;
              out_hi   <= 1'b1;
              state    <= SEND_HI;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
              if (done_cnt != '1) done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        SEND_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
            if (done_cnt != '1) done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the ALU: captures the ALU's Zhighout/Zlowout pair into the Z register pair on a start pulse.
- Delivers the result to the register-file write port over a valid/ready handshake.
- Multiply (op 01111) and divide (op 10000) are 64-bit ops: they drain as two words, LO then HI. All other ops drain as one word (Zlow only).
- Also produces zero/negative flags and a sticky overrun flag for the control unit.

Parameters:
- WIDTH, 32, data word width; Z pair is 2*WIDTH.
- OP_MUL, 5'b01111, op code treated as 64-bit multiply.
- OP_DIV, 5'b10000, op code treated as 64-bit divide (LO=quotient, HI=remainder).
- CNT_W, 8, width of the saturating completed-result counter.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-low.
- Zlowin  in  WIDTH  ALU Zlowout.
- Zhighin  in  WIDTH  ALU Zhighout.
- op  in  5  ALU op code, same cycle as start.
- start  in  1  single-cycle capture request from control.
- out_ready  in  1  register file accepts out_data this cycle.
- ovr_ack  in  1  clears overrun flag.
- out_valid  out  1  out_data/out_hi valid.
- out_data  out  WIDTH  word being written.
- out_hi  out  1  0 = LO/Z word, 1 = HI word.
- busy  out  1  stage not idle.
- Zlow_q  out  WIDTH  captured low word.
- Zhigh_q  out  WIDTH  captured high word.
- zero_flag  out  1  captured result == 0 (64-bit for mul/div, low word otherwise).
- neg_flag  out  1  MSB of captured result (Zhigh_q[WIDTH-1] for mul/div, else Zlow_q[WIDTH-1]).
- overrun  out  1  sticky: start arrived while busy.
- done_cnt  out  CNT_W  completed results, saturating.

Behaviour:
- Reset (clear=0, async): state IDLE; all outputs 0 (out_valid=0, busy=0, Zlow_q=Zhigh_q=0, flags 0, overrun=0, done_cnt=0).
- States: IDLE, SEND_LO, SEND_HI.
- IDLE + start=1:
  - Capture Zlowin/Zhighin into Zlow_q/Zhigh_q.
  - Latch wide = (op==OP_MUL || op==OP_DIV); compute flags from the captured values.
  - Go to SEND_LO next edge. out_valid rises the cycle after start (latency 1).
  - For a non-wide op, Zhigh_q is still captured, but zero_flag/neg_flag use the low word only.
- SEND_LO: out_valid=1, out_data=Zlow_q, out_hi=0.
  - On out_valid&&out_ready: go to SEND_HI if wide; else go to IDLE and increment done_cnt.
  - out_data is held stable while out_ready=0.
- SEND_HI: out_valid=1, out_data=Zhigh_q, out_hi=1.
  - On handshake: go to IDLE and increment done_cnt.
- busy=1 in SEND_LO and SEND_HI.
- out_valid must not drop without a handshake.
- start while busy: ignored (Z pair and flags unchanged) and overrun set.
- Start in the same cycle as the final handshake: still counts as busy, so it is ignored and overrun is set. Back-to-back results need one IDLE cycle.
- overrun is cleared by ovr_ack=1. ovr_ack and a new overrun event in the same cycle leaves overrun=1 (set wins).
- done_cnt saturates at 2^CNT_W-1 and does not wrap.
- Flags and Z pair hold their values until the next accepted start.
- clear asserted mid-transfer: immediate return to IDLE, out_valid=0; the partial transfer is discarded and not counted.
- op values outside the ALU's decoded set are treated as non-wide.

Test Plan:
- Add, single word:
  - Stimulus: op=00011, Zlowin=0x0000_0005, Zhighin=0x0, start; out_ready=1.
  - Required: out_valid next cycle with out_data=0x5, out_hi=0, one beat; done_cnt=1; zero=0, neg=0.
- Mul, two words with stall:
  - Stimulus: op=01111, Zhighin=0xFFFF_FFFF, Zlowin=0xFFFF_FFFE; out_ready low for 3 cycles, then high.
  - Required: LO word 0xFFFF_FFFE held 3 cycles, then HI word 0xFFFF_FFFF with out_hi=1; neg=1; done_cnt=1.
- Div, zero result:
  - Stimulus: op=10000, both words 0.
  - Required: two beats, zero_flag=1. Same zero values with op=00100 give one beat, zero_flag=1.
- Overrun:
  - Stimulus: start pulsed during SEND_HI, and separately in the same cycle as the final handshake.
  - Required: overrun=1 both times, Z pair unchanged. ovr_ack clears it; ovr_ack coincident with a new overrun event leaves overrun=1.
- Reset mid-transfer:
  - Stimulus: clear low asynchronously (between edges) during SEND_LO.
  - Required: out_valid=0 and busy=0 immediately; done_cnt unchanged (0 after reset).
- Saturation:
  - Stimulus: CNT_W=2, 5 completed results.
  - Required: done_cnt stops at 3.
